// File: rtl/trigger_mstage_pkg.sv
// Shared types for the multi-stage trigger.
//  - mode_e   : per-stage compare mode
//  - state_e  : top-level sequencer state
//  - cfg_t    : per-stage configuration word as written through cmd_i
//  - cfg_unpack() : turns a raw 32-bit command word into cfg_t, reserved bits zeroed
package trigger_mstage_pkg;

    typedef enum logic [1:0] {
        MODE_MATCH  = 2'b00,
        MODE_RISE   = 2'b01,
        MODE_FALL   = 2'b10,
        MODE_CHANGE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    // Bit positions of the configuration fields inside cmd_i.
    localparam int CFG_DELAY_LSB = 0;
    localparam int CFG_LEVEL_LSB = 16;
    localparam int CFG_MODE_LSB  = 18;
    localparam int CFG_START_BIT = 27;
    localparam int CFG_OCC_LSB   = 28;

    typedef struct packed {
        logic [3:0]  occ;     // hits needed = occ + 1
        logic        start;   // completion fires capture instead of advancing level
        logic [6:0]  rsvd;
        mode_e       mode;
        logic [1:0]  level;   // level at which this stage is evaluated
        logic [15:0] delay;   // strobes between match and completion
    } cfg_t;

    function automatic cfg_t cfg_unpack(input logic [31:0] raw);
        cfg_t c;
        c.occ   = raw[CFG_OCC_LSB +: 4];
        c.start = raw[CFG_START_BIT];
        c.rsvd  = '0;
        c.mode  = mode_e'(raw[CFG_MODE_LSB +: 2]);
        c.level = raw[CFG_LEVEL_LSB +: 2];
        c.delay = raw[CFG_DELAY_LSB +: 16];
        return c;
    endfunction

endpackage

// File: rtl/trigger_mstage_if.sv
// Command / sample / status bundle of the multi-stage trigger.
//  master : drives commands and samples, observes run/armed/level
//  slave  : the trigger itself
//  cmd_i, exec_i, set_*_i, stg_i : configuration writes
//  arm_i                         : arm pulse
//  stb_i, smpls_i                : sample strobe and word
//  run_o, armed_o, lvl_o         : status
interface trigger_mstage_if #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int LVL_W  = 2
);
    localparam int SW = $clog2(STAGES);

    logic [31:0]      cmd_i;
    logic             exec_i;
    logic             set_mask_i;
    logic             set_val_i;
    logic             set_cfg_i;
    logic [SW-1:0]    stg_i;
    logic             arm_i;
    logic             stb_i;
    logic [WIDTH-1:0] smpls_i;
    logic             run_o;
    logic             armed_o;
    logic [LVL_W-1:0] lvl_o;

    modport master (
        output cmd_i, exec_i, set_mask_i, set_val_i, set_cfg_i, stg_i,
        output arm_i, stb_i, smpls_i,
        input  run_o, armed_o, lvl_o
    );

    modport slave (
        input  cmd_i, exec_i, set_mask_i, set_val_i, set_cfg_i, stg_i,
        input  arm_i, stb_i, smpls_i,
        output run_o, armed_o, lvl_o
    );
endinterface

// File: rtl/trigger_mstage_stage.sv
// One trigger stage: mask/value/config registers, occurrence and delay counters.
//  clk_i, rst_in  : clock, asynchronous active-low reset
//  clr_i          : arm pulse, clears counters (not configuration)
//  act_i          : strobe that this stage must evaluate (armed, level matches)
//  we_*_i, cmd_i  : register writes
//  smpl_i, prev_i, prev_vld_i : current sample, previous sample and its validity
//  level_o, start_o : configured level and start flag
//  done_o         : stage completes on the current strobe (combinational)
module trigger_mstage_stage
    import trigger_mstage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DLY_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             clr_i,
    input  logic             act_i,
    input  logic             we_mask_i,
    input  logic             we_val_i,
    input  logic             we_cfg_i,
    input  logic [31:0]      cmd_i,
    input  logic [WIDTH-1:0] smpl_i,
    input  logic [WIDTH-1:0] prev_i,
    input  logic             prev_vld_i,
    output logic [1:0]       level_o,
    output logic             start_o,
    output logic             done_o
);

    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] value_reg;
    cfg_t             cfg_reg;
    logic [3:0]       occ_cnt_reg, occ_cnt_next;
    logic [DLY_W-1:0] dly_cnt_reg, dly_cnt_next;
    logic             busy_reg, busy_next;
    logic             hit;
    logic [DLY_W-1:0] dly_load;
    logic             unused_rsvd;

    assign unused_rsvd = ^cfg_reg.rsvd;
    assign level_o     = cfg_reg.level;
    assign start_o     = cfg_reg.start;
    assign dly_load    = DLY_W'(cfg_reg.delay);

    // Edge modes need a valid previous sample, so the first strobe after arm never hits.
    always_comb begin
        hit = 1'b0;
        case (cfg_reg.mode)
            MODE_MATCH:  hit = ((smpl_i ^ value_reg) & mask_reg) == '0;
            MODE_RISE:   hit = prev_vld_i && ((~prev_i & smpl_i & mask_reg & value_reg) != '0);
            MODE_FALL:   hit = prev_vld_i && ((prev_i & ~smpl_i & mask_reg & value_reg) != '0);
            MODE_CHANGE: hit = prev_vld_i && (((prev_i ^ smpl_i) & mask_reg) != '0);
            default:     hit = 1'b0;
        endcase
    end

    // While the delay runs the stage ignores hits and only counts strobes down.
    always_comb begin
        occ_cnt_next = occ_cnt_reg;
        dly_cnt_next = dly_cnt_reg;
        busy_next    = busy_reg;
        done_o       = 1'b0;
        if (clr_i) begin
            occ_cnt_next = '0;
            dly_cnt_next = '0;
            busy_next    = 1'b0;
        end else if (act_i) begin
            if (busy_reg) begin
                dly_cnt_next = dly_cnt_reg - DLY_W'(1);
                if (dly_cnt_reg == DLY_W'(1)) begin
                    busy_next = 1'b0;
                    done_o    = 1'b1;
                end
            end else if (hit) begin
                if (occ_cnt_reg == cfg_reg.occ) begin
                    occ_cnt_next = '0;
                    if (dly_load == '0) begin
                        done_o = 1'b1;
                    end else begin
                        dly_cnt_next = dly_load;
                        busy_next    = 1'b1;
                    end
                end else begin
                    occ_cnt_next = occ_cnt_reg + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            mask_reg    <= '0;
            value_reg   <= '0;
            cfg_reg     <= '0;
            occ_cnt_reg <= '0;
            dly_cnt_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            if (we_mask_i) mask_reg  <= cmd_i[WIDTH-1:0];
            if (we_val_i)  value_reg <= cmd_i[WIDTH-1:0];
            if (we_cfg_i)  cfg_reg   <= cfg_unpack(cmd_i);
            occ_cnt_reg <= occ_cnt_next;
            dly_cnt_reg <= dly_cnt_next;
            busy_reg    <= busy_next;
        end
    end

endmodule

// File: rtl/trigger_mstage.sv
// Multi-stage sample trigger with level sequencer.
//  clk_i  : clock
//  rst_in : asynchronous active-low reset, clears configuration as well
//  bus    : trigger_mstage_if.slave (commands, samples, run/armed/level status)
// The top owns the IDLE/ARMED/RUN sequencer, the current level and the
// previous sample; each stage reports completion for the current strobe.
module trigger_mstage
    import trigger_mstage_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int LVL_W  = 2,
    parameter int DLY_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_in,
    trigger_mstage_if.slave  bus
);

    state_e           state_reg, state_next;
    logic             run_reg, run_next;
    logic [LVL_W-1:0] lvl_reg, lvl_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic             prev_vld_reg, prev_vld_next;

    logic [STAGES-1:0] done_w;
    logic [STAGES-1:0] start_w;
    logic [STAGES-1:0] act_w;
    logic [1:0]        level_w [STAGES];
    logic              armed_stb;
    logic              fire;
    logic              advance;

    // Arm takes precedence over a coincident strobe.
    assign armed_stb = (state_reg == ST_ARMED) && bus.stb_i && !bus.arm_i;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic sel;
            assign sel       = bus.exec_i && (int'(bus.stg_i) == gi);
            assign act_w[gi] = armed_stb &&
                               ((LVL_W + 2)'(level_w[gi]) == (LVL_W + 2)'(lvl_reg));

            trigger_mstage_stage #(
                .WIDTH (WIDTH),
                .DLY_W (DLY_W)
            ) u_stage (
                .clk_i      (clk_i),
                .rst_in     (rst_in),
                .clr_i      (bus.arm_i),
                .act_i      (act_w[gi]),
                .we_mask_i  (sel && bus.set_mask_i),
                .we_val_i   (sel && bus.set_val_i),
                .we_cfg_i   (sel && bus.set_cfg_i),
                .cmd_i      (bus.cmd_i),
                .smpl_i     (bus.smpls_i),
                .prev_i     (prev_reg),
                .prev_vld_i (prev_vld_reg),
                .level_o    (level_w[gi]),
                .start_o    (start_w[gi]),
                .done_o     (done_w[gi])
            );
        end
    endgenerate

    assign fire    = |(done_w & start_w);
    assign advance = |(done_w & ~start_w);

    // Fire and level advance are independent: both may happen on one strobe,
    // and the level moves by one no matter how many stages completed.
    always_comb begin
        state_next    = state_reg;
        run_next      = run_reg;
        lvl_next      = lvl_reg;
        prev_next     = prev_reg;
        prev_vld_next = prev_vld_reg;
        if (bus.arm_i) begin
            state_next    = ST_ARMED;
            run_next      = 1'b0;
            lvl_next      = '0;
            prev_vld_next = 1'b0;
        end else if (armed_stb) begin
            prev_next     = bus.smpls_i;
            prev_vld_next = 1'b1;
            if (advance && (lvl_reg != {LVL_W{1'b1}})) begin
                lvl_next = lvl_reg + LVL_W'(1);
            end
            if (fire) begin
                state_next = ST_RUN;
                run_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_reg    <= ST_IDLE;
            run_reg      <= 1'b0;
            lvl_reg      <= '0;
            prev_reg     <= '0;
            prev_vld_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            run_reg      <= run_next;
            lvl_reg      <= lvl_next;
            prev_reg     <= prev_next;
            prev_vld_reg <= prev_vld_next;
        end
    end

    assign bus.run_o   = run_reg;
    assign bus.armed_o = (state_reg == ST_ARMED);
    assign bus.lvl_o   = lvl_reg;

endmodule

// File: tb/tb_trigger_mstage.sv
// Directed bench for trigger_mstage (8 stages, 8-bit samples).
// Inputs change on the falling edge; outputs are read on the following falling edge.
module tb_trigger_mstage;

    localparam int STAGES = 8;
    localparam int WIDTH  = 8;
    localparam int LVL_W  = 2;
    localparam int DLY_W  = 16;
    localparam int SW     = $clog2(STAGES);

    // Rise mode with a zero mask can never hit: used to keep unused stages quiet.
    localparam logic [31:0] CFG_PARK = 32'h0004_0000;
    localparam int K_MASK = 0;
    localparam int K_VAL  = 1;
    localparam int K_CFG  = 2;

    logic clk_i = 1'b0;
    logic rst_in;
    int   n_checks = 0;
    int   n_errors = 0;

    trigger_mstage_if #(.STAGES(STAGES), .WIDTH(WIDTH), .LVL_W(LVL_W)) bus ();

    trigger_mstage #(
        .STAGES (STAGES),
        .WIDTH  (WIDTH),
        .LVL_W  (LVL_W),
        .DLY_W  (DLY_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic check_outs(input string tag, input logic r, input logic a, input logic [1:0] l);
        check_val({tag, ".run"},   {31'd0, bus.run_o},   {31'd0, r});
        check_val({tag, ".armed"}, {31'd0, bus.armed_o}, {31'd0, a});
        check_val({tag, ".lvl"},   {30'd0, bus.lvl_o},   {30'd0, l});
    endtask

    task automatic reg_write(input int kind, input int s, input logic [31:0] d, input logic ex);
        bus.exec_i     = ex;
        bus.stg_i      = SW'(s);
        bus.cmd_i      = d;
        bus.set_mask_i = (kind == K_MASK);
        bus.set_val_i  = (kind == K_VAL);
        bus.set_cfg_i  = (kind == K_CFG);
        @(negedge clk_i);
        bus.exec_i     = 1'b0;
        bus.set_mask_i = 1'b0;
        bus.set_val_i  = 1'b0;
        bus.set_cfg_i  = 1'b0;
    endtask

    task automatic setup_stage(input int s, input logic [7:0] m, input logic [7:0] v, input logic [31:0] c);
        reg_write(K_MASK, s, {24'd0, m}, 1'b1);
        reg_write(K_VAL,  s, {24'd0, v}, 1'b1);
        reg_write(K_CFG,  s, c, 1'b1);
    endtask

    task automatic park_all();
        for (int s = 0; s < STAGES; s++) begin
            reg_write(K_MASK, s, 32'd0, 1'b1);
            reg_write(K_CFG,  s, CFG_PARK, 1'b1);
        end
    endtask

    task automatic cyc(input logic arm, input logic stb, input logic [7:0] v);
        bus.arm_i   = arm;
        bus.stb_i   = stb;
        bus.smpls_i = v;
        @(negedge clk_i);
        bus.arm_i   = 1'b0;
        bus.stb_i   = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v);
        cyc(1'b0, 1'b1, v);
    endtask

    task automatic arm();
        cyc(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in         = 1'b0;
        bus.cmd_i      = '0;
        bus.exec_i     = 1'b0;
        bus.set_mask_i = 1'b0;
        bus.set_val_i  = 1'b0;
        bus.set_cfg_i  = 1'b0;
        bus.stg_i      = '0;
        bus.arm_i      = 1'b0;
        bus.stb_i      = 1'b0;
        bus.smpls_i    = '0;
        repeat (2) @(negedge clk_i);
        rst_in = 1'b1;
        check_outs("reset", 1'b0, 1'b0, 2'd0);

        // Single-stage parallel fire; arm coinciding with a strobe wins.
        park_all();
        setup_stage(0, 8'hFF, 8'h5A, 32'h0800_0000);
        arm();
        check_outs("t2.armed", 1'b0, 1'b1, 2'd0);
        strobe(8'h00);
        check_outs("t2.nomatch", 1'b0, 1'b1, 2'd0);
        cyc(1'b1, 1'b1, 8'h5A);
        check_outs("t2.arm_stb", 1'b0, 1'b1, 2'd0);
        strobe(8'h5A);
        check_outs("t2.fire", 1'b1, 1'b0, 2'd0);

        // Two levels, second with delay 3.
        setup_stage(0, 8'hFF, 8'h01, 32'h0000_0000);
        setup_stage(1, 8'hFF, 8'h02, 32'h0801_0003);
        arm();
        check_outs("t3.armed", 1'b0, 1'b1, 2'd0);
        strobe(8'h01);
        check_outs("t3.lvl1", 1'b0, 1'b1, 2'd1);
        strobe(8'h02);
        check_outs("t3.match", 1'b0, 1'b1, 2'd1);
        strobe(8'h00);
        check_val("t3.dly2.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h00);
        check_val("t3.dly1.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h00);
        check_outs("t3.fire", 1'b1, 1'b0, 2'd1);
        strobe(8'h01);
        check_outs("t3.frozen", 1'b1, 1'b0, 2'd1);

        // Asynchronous reset in RUN drops outputs without a clock edge.
        #2;
        rst_in = 1'b0;
        #1;
        check_outs("t1.async", 1'b0, 1'b0, 2'd0);
        @(negedge clk_i);
        rst_in = 1'b1;
        strobe(8'h01);
        check_outs("t1.idle_stb", 1'b0, 1'b0, 2'd0);
        // Cleared configuration: every stage is a mask-0 level-0 match.
        arm();
        strobe(8'h00);
        check_outs("t1.cfg_cleared", 1'b0, 1'b1, 2'd1);

        // Rise with occurrence count 2: fires on the third rising edge.
        park_all();
        setup_stage(0, 8'h01, 8'h01, 32'h2804_0000);
        arm();
        strobe(8'h00);
        check_val("t4.s0.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h01);
        check_val("t4.r1.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h00);
        check_val("t4.s2.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h01);
        check_val("t4.r2.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h00);
        check_val("t4.s4.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h01);
        check_outs("t4.r3", 1'b1, 1'b0, 2'd0);

        // Edge mode on the first strobe after arm, with a known-zero old sample.
        setup_stage(0, 8'h01, 8'h01, 32'h0804_0000);
        arm();
        strobe(8'h00);
        arm();
        strobe(8'h01);
        check_outs("t5.first", 1'b0, 1'b1, 2'd0);
        strobe(8'h00);
        strobe(8'h01);
        check_outs("t5.rise", 1'b1, 1'b0, 2'd0);

        // Arm during delay clears the countdown.
        setup_stage(0, 8'hFF, 8'h3C, 32'h0800_0002);
        arm();
        strobe(8'h3C);
        check_val("t5.dly_load.run", {31'd0, bus.run_o}, 32'd0);
        arm();
        for (int i = 0; i < 3; i++) begin
            strobe(8'h00);
            check_outs($sformatf("t5.rearm%0d", i), 1'b0, 1'b1, 2'd0);
        end
        strobe(8'h3C);
        strobe(8'h00);
        check_val("t5.dly1.run", {31'd0, bus.run_o}, 32'd0);
        strobe(8'h00);
        check_outs("t5.dly_fire", 1'b1, 1'b0, 2'd0);

        // Stage 7 addressing and a write with exec low.
        park_all();
        setup_stage(7, 8'hFF, 8'h33, 32'h0800_0000);
        reg_write(K_VAL, 7, 32'h0000_0044, 1'b0);
        arm();
        strobe(8'h44);
        check_outs("t6.noexec", 1'b0, 1'b1, 2'd0);
        strobe(8'h33);
        check_outs("t6.stg7", 1'b1, 1'b0, 2'd0);

        // Start stage and level stage complete on the same strobe.
        reg_write(K_MASK, 7, 32'd0, 1'b1);
        reg_write(K_CFG,  7, CFG_PARK, 1'b1);
        setup_stage(0, 8'hFF, 8'h77, 32'h0800_0000);
        setup_stage(1, 8'hFF, 8'h77, 32'h0000_0000);
        arm();
        strobe(8'h77);
        check_outs("t6.simul", 1'b1, 1'b0, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
